// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDSUB,
        ST_MUL,
        ST_DIV,
        ST_DIV_FIX,
        ST_DONE
    } alu_state_t;

endpackage

// File: rtl/alu_nr_div_core.sv
// Non-restoring divider datapath on unsigned magnitudes: load, one iteration per step,
// and a single corrective add of the divisor when the final remainder is negative.
module alu_nr_div_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   div_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   stepped;

    // The sign of the previous partial remainder picks add or subtract; wrap-around of
    // the doubled remainder is harmless because the post-add/sub value is always in range.
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        stepped = rem_q[WIDTH] ? (shifted + div_q) : (shifted - div_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
        end else if (ld) begin
            rem_q <= '0;
            div_q <= {1'b0, divisor};
            quo_q <= dividend;
        end else if (step) begin
            rem_q <= stepped;
            quo_q <= {quo_q[WIDTH-2:0], ~stepped[WIDTH]};
        end else if (fix && rem_q[WIDTH]) begin
            rem_q <= rem_q + div_q;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_param.sv
// Multi-cycle ALU: ADD/SUB, radix-2 Booth MUL and non-restoring DIV with signed/unsigned
// operands, a busy/done handshake and sticky divide-by-zero / overflow flags.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op_code,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   operand_A,
    input  logic [WIDTH-1:0]   operand_B,
    output logic [2*WIDTH-1:0] alu_result,
    output logic               alu_done,
    output logic               busy,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    alu_state_t       state, next_state;
    logic             phase;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             sgn_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic accept, addsub_ld, booth_ld, booth_step, div_ld, div_step, div_fix, finish;

    logic [WIDTH:0]     ext_sum;
    logic [WIDTH-1:0]   s_sum;
    logic               is_sub, addsub_ovf, work_ovf;
    logic [2*WIDTH-1:0] addsub_res, work_res;

    logic [WIDTH+1:0] booth_acc, booth_m_ext, booth_sum;
    logic [WIDTH:0]   booth_mq, booth_m;
    logic             booth_qm1;

    logic             a_neg, b_neg, b_zero, div_min_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, quo_mag, rem_mag, div_quo, div_rem;

    logic [2*WIDTH-1:0] fin_res;
    logic               fin_ovf, fin_dbz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Every op state spends its first cycle (phase=0) loading its datapath from the
    // latched operands; cnt then counts iterations and the final cycle writes the result.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        addsub_ld  = 1'b0;
        booth_ld   = 1'b0;
        booth_step = 1'b0;
        div_ld     = 1'b0;
        div_step   = 1'b0;
        div_fix    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    case (op_code)
                        OP_MUL:  next_state = ST_MUL;
                        OP_DIV:  next_state = ST_DIV;
                        default: next_state = ST_ADDSUB;
                    endcase
                end
            end
            ST_ADDSUB: begin
                if (!phase) addsub_ld = 1'b1;
                else begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_MUL: begin
                if (!phase) booth_ld = 1'b1;
                else if (cnt == CNT_W'(WIDTH + 1)) begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end else booth_step = 1'b1;
            end
            ST_DIV: begin
                if (!phase) div_ld = 1'b1;
                else if (b_zero) begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end else begin
                    div_step = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) next_state = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                if (!phase) div_fix = 1'b1;
                else begin
                    finish     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
            cnt   <= '0;
        end else if (next_state != state || state == ST_IDLE) begin
            phase <= 1'b0;
            cnt   <= '0;
        end else if (!phase) begin
            phase <= 1'b1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_ADD;
            sgn_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (accept) begin
            op_q  <= op_code;
            sgn_q <= signed_mode;
            a_q   <= operand_A;
            b_q   <= operand_B;
        end
    end

    // Unsigned keeps the (WIDTH+1)-bit carry/borrow; signed sign-extends the WIDTH-bit sum.
    always_comb begin
        is_sub  = (op_q == OP_SUB);
        ext_sum = is_sub ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
        s_sum   = ext_sum[WIDTH-1:0];
        if (sgn_q) begin
            addsub_res = {{WIDTH{s_sum[WIDTH-1]}}, s_sum};
            addsub_ovf = (is_sub ? (a_q[WIDTH-1] != b_q[WIDTH-1]) : (a_q[WIDTH-1] == b_q[WIDTH-1]))
                         && (s_sum[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
            addsub_res = {{(WIDTH-1){1'b0}}, ext_sum};
            addsub_ovf = ext_sum[WIDTH];
        end
    end

    always_comb begin
        booth_m_ext = {booth_m[WIDTH], booth_m};
        case ({booth_mq[0], booth_qm1})
            2'b01:   booth_sum = booth_acc + booth_m_ext;
            2'b10:   booth_sum = booth_acc - booth_m_ext;
            default: booth_sum = booth_acc;
        endcase
    end

    // Operands widen to WIDTH+1 bits so unsigned values stay positive for Booth recoding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            booth_acc <= '0;
            booth_mq  <= '0;
            booth_m   <= '0;
            booth_qm1 <= 1'b0;
            work_res  <= '0;
            work_ovf  <= 1'b0;
        end else begin
            if (addsub_ld) begin
                work_res <= addsub_res;
                work_ovf <= addsub_ovf;
            end
            if (booth_ld) begin
                booth_acc <= '0;
                booth_mq  <= {sgn_q & b_q[WIDTH-1], b_q};
                booth_m   <= {sgn_q & a_q[WIDTH-1], a_q};
                booth_qm1 <= 1'b0;
            end else if (booth_step) begin
                booth_acc <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
                booth_mq  <= {booth_sum[0], booth_mq[WIDTH:1]};
                booth_qm1 <= booth_mq[0];
            end
        end
    end

    always_comb begin
        a_neg       = sgn_q & a_q[WIDTH-1];
        b_neg       = sgn_q & b_q[WIDTH-1];
        a_mag       = a_neg ? -a_q : a_q;
        b_mag       = b_neg ? -b_q : b_q;
        b_zero      = (b_q == '0);
        div_quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
        div_rem     = a_neg ? -rem_mag : rem_mag;
        div_min_ovf = sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    end

    alu_nr_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .ld        (div_ld),
        .step      (div_step),
        .fix       (div_fix),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo_mag),
        .remainder (rem_mag)
    );

    // Selected only in the cycle that finishes; ST_DIV finishing means divide-by-zero.
    always_comb begin
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_dbz = 1'b0;
        case (state)
            ST_ADDSUB: begin
                fin_res = work_res;
                fin_ovf = work_ovf;
            end
            ST_MUL:     fin_res = {booth_acc[WIDTH-2:0], booth_mq};
            ST_DIV: begin
                fin_res = {a_q, {WIDTH{1'b1}}};
                fin_dbz = 1'b1;
            end
            ST_DIV_FIX: begin
                fin_res = {div_rem, div_quo};
                fin_ovf = div_min_ovf;
            end
            default: fin_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result  <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (finish) begin
            alu_result  <= fin_res;
            div_by_zero <= fin_dbz;
            overflow    <= fin_ovf;
        end
    end

    assign alu_done = (state == ST_DONE);
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_alu_seq_param;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
        int          acc_cyc;
        int          lat;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst8, start8, sgn8, done8, busy8, dbz8, ovf8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rst16, start16, sgn16, done16, busy16, dbz16, ovf16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic [31:0] res16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt8 = 0;
    int   base_done;
    exp_t q8[$];
    exp_t q16[$];
    exp_t m8e, m16e;
    logic last_ovf[2];
    logic last_dbz[2];

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .op_code(op8), .signed_mode(sgn8),
        .operand_A(a8), .operand_B(b8), .alu_result(res8), .alu_done(done8),
        .busy(busy8), .div_by_zero(dbz8), .overflow(ovf8)
    );

    alu_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst16), .start(start16), .op_code(op16), .signed_mode(sgn16),
        .operand_A(a16), .operand_B(b16), .alu_result(res16), .alu_done(done16),
        .busy(busy16), .div_by_zero(dbz16), .overflow(ovf16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors pop one expectation per done pulse and compare result, flags and latency.
    always @(negedge clk) begin
        if (!rst8 && done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL w8_unexpected_done: got done=1 expected done=0");
            end else begin
                m8e = q8.pop_front();
                checkOutput({m8e.tag, "_res"}, {16'h0, res8}, m8e.res);
                checkOutput({m8e.tag, "_ovf"}, {31'h0, ovf8}, {31'h0, m8e.ovf});
                checkOutput({m8e.tag, "_dbz"}, {31'h0, dbz8}, {31'h0, m8e.dbz});
                checkOutput({m8e.tag, "_lat"}, 32'(cyc - m8e.acc_cyc), 32'(m8e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst16 && done16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL w16_unexpected_done: got done=1 expected done=0");
            end else begin
                m16e = q16.pop_front();
                checkOutput({m16e.tag, "_res"}, res16, m16e.res);
                checkOutput({m16e.tag, "_ovf"}, {31'h0, ovf16}, {31'h0, m16e.ovf});
                checkOutput({m16e.tag, "_dbz"}, {31'h0, dbz16}, {31'h0, m16e.dbz});
                checkOutput({m16e.tag, "_lat"}, 32'(cyc - m16e.acc_cyc), 32'(m16e.lat));
            end
        end
    end

    // Issues one operation, checks sticky flags before and their clearing after accept,
    // then waits (bounded) for the monitor to consume the expectation.
    task automatic applyStimulus(input bit wide, input logic [1:0] op, input logic sgn,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [31:0] res, input logic ovf, input logic dbz,
                                 input int lat, input string tag);
        exp_t e;
        bit   idle;
        @(negedge clk);
        checkOutput({tag, "_sticky_ovf"}, {31'h0, wide ? ovf16 : ovf8}, {31'h0, last_ovf[wide]});
        checkOutput({tag, "_sticky_dbz"}, {31'h0, wide ? dbz16 : dbz8}, {31'h0, last_dbz[wide]});
        e.res = res; e.ovf = ovf; e.dbz = dbz; e.acc_cyc = cyc + 1; e.lat = lat; e.tag = tag;
        if (wide) begin
            op16 = op; sgn16 = sgn; a16 = a; b16 = b; start16 = 1'b1;
            q16.push_back(e);
        end else begin
            op8 = op; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
        checkOutput({tag, "_busy"}, {31'h0, wide ? busy16 : busy8}, 32'h1);
        checkOutput({tag, "_clr_flags"}, {30'h0, wide ? ovf16 : ovf8, wide ? dbz16 : dbz8}, 32'h0);
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((wide ? q16.size() : q8.size()) == 0) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 100 cycles", tag);
            if (wide) q16.delete(); else q8.delete();
        end
        last_ovf[wide] = ovf;
        last_dbz[wide] = dbz;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst8 = 1'b1; start8 = 1'b0; op8 = ADD; sgn8 = 1'b0; a8 = '0; b8 = '0;
        rst16 = 1'b1; start16 = 1'b0; op16 = ADD; sgn16 = 1'b0; a16 = '0; b16 = '0;
        last_ovf[0] = 1'b0; last_ovf[1] = 1'b0; last_dbz[0] = 1'b0; last_dbz[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);
        checkOutput("rst8_state", {res8, 12'h0, done8, busy8, dbz8, ovf8}, 32'h0);
        checkOutput("rst16_res", res16, 32'h0);
        checkOutput("rst16_ctl", {28'h0, done16, busy16, dbz16, ovf16}, 32'h0);

        applyStimulus(0, ADD, 0, 16'd200,  16'd100,  32'h012C, 1, 0, 2,  "u_add_carry");
        applyStimulus(0, SUB, 1, 16'd100,  16'h009C, 32'hFFC8, 1, 0, 2,  "s_sub_ovf");
        applyStimulus(0, SUB, 0, 16'd5,    16'd7,    32'h01FE, 1, 0, 2,  "u_sub_borrow");
        applyStimulus(0, ADD, 1, 16'h007F, 16'h0001, 32'hFF80, 1, 0, 2,  "s_add_ovf");
        applyStimulus(0, ADD, 1, 16'h00FD, 16'h0002, 32'hFFFF, 0, 0, 2,  "s_add_neg");
        applyStimulus(0, MUL, 1, 16'h00FB, 16'h0006, 32'hFFE2, 0, 0, 11, "s_mul");
        applyStimulus(0, MUL, 0, 16'h00FF, 16'h00FF, 32'hFE01, 0, 0, 11, "u_mul_max");
        applyStimulus(0, MUL, 1, 16'h0080, 16'h0080, 32'h4000, 0, 0, 11, "s_mul_min");
        applyStimulus(0, DIV, 0, 16'd40,   16'd6,    32'h0406, 0, 0, 11, "u_div");
        applyStimulus(0, DIV, 1, 16'h00F9, 16'h0002, 32'hFFFD, 0, 0, 11, "s_div_neg_a");
        applyStimulus(0, DIV, 1, 16'h0007, 16'h00FE, 32'h01FD, 0, 0, 11, "s_div_neg_b");
        applyStimulus(0, DIV, 1, 16'h0080, 16'h00FF, 32'h0080, 1, 0, 11, "s_div_min");
        applyStimulus(0, DIV, 0, 16'd255,  16'd16,   32'h0F0F, 0, 0, 11, "u_div_max");
        applyStimulus(0, DIV, 0, 16'h004D, 16'h0000, 32'h4DFF, 0, 1, 2,  "div_zero");
        applyStimulus(0, ADD, 0, 16'd1,    16'd2,    32'h0003, 0, 0, 2,  "add_after_dz");

        // Starts held while busy and pulsed during DONE, with operands changing mid-MUL.
        @(negedge clk);
        base_done = done_cnt8;
        m8e.res = 32'h000C; m8e.ovf = 1'b0; m8e.dbz = 1'b0; m8e.acc_cyc = cyc + 1;
        m8e.lat = 11; m8e.tag = "ign_mul";
        q8.push_back(m8e);
        op8 = MUL; sgn8 = 1'b0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
        @(negedge clk);
        op8 = ADD; a8 = 8'hAA; b8 = 8'h55;
        repeat (4) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done8) break;
            @(negedge clk);
        end
        start8 = 1'b1; op8 = ADD; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("ign_done_count", 32'(done_cnt8 - base_done), 32'h1);
        checkOutput("ign_busy_idle", {31'h0, busy8}, 32'h0);

        // Reset during a 16-bit divide, then a fresh multiply.
        applyStimulus(1, ADD, 0, 16'd1000, 16'd234, 32'h000004D2, 0, 0, 2, "w16_add");
        @(negedge clk);
        op16 = DIV; sgn16 = 1'b0; a16 = 16'd5000; b16 = 16'd7; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("w16_busy_mid_div", {31'h0, busy16}, 32'h1);
        #2 rst16 = 1'b1;
        #1;
        checkOutput("w16_rst_res", res16, 32'h0);
        checkOutput("w16_rst_ctl", {28'h0, done16, busy16, dbz16, ovf16}, 32'h0);
        @(negedge clk);
        rst16 = 1'b0;
        last_ovf[1] = 1'b0;
        last_dbz[1] = 1'b0;
        applyStimulus(1, MUL, 1, 16'd300,  16'hFFFE, 32'hFFFFFDA8, 0, 0, 19, "w16_mul");
        applyStimulus(1, DIV, 1, 16'hFC18, 16'd7,    32'hFFFAFF72, 0, 0, 19, "w16_div");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised multi-cycle ALU and the next generation of the 8-bit ADD/SUB/Booth-MUL/non-restoring-DIV ALU. Operand width is generic. It adds a signed/unsigned mode, a busy/done handshake, and divide-by-zero and overflow flags. It sits under the system controller, which issues one operation at a time via start and collects result on done.

Parameters:
WIDTH, 8, operand width in bits (>=4); result is 2*WIDTH.
CNT_W, $clog2(WIDTH+2), iteration counter width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
op_code  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
operand_A  in  WIDTH  addend/minuend/multiplicand/dividend
operand_B  in  WIDTH  addend/subtrahend/multiplier/divisor
alu_result  out  2*WIDTH  registered result, held until the next done
alu_done  out  1  one-cycle pulse, result and flags valid
busy  out  1  high from the accepting edge until the edge that raises done
div_by_zero  out  1  sticky until next accepted start
overflow  out  1  sticky until next accepted start

Behaviour:
- Reset (async, any state): FSM=IDLE; alu_result=0, alu_done=0, busy=0, div_by_zero=0, overflow=0; counter and working registers cleared. Reset mid-operation aborts it with no done.
- Accept: edge E where state=IDLE and start=1. Latch op_code, signed_mode, A, B. Clear flags. busy=1. start is ignored while busy=1. Input changes after E have no effect.
- FSM states: IDLE, ADDSUB, MUL, DIV, DIV_FIX, DONE. DONE lasts one cycle (alu_done=1, busy=0) and returns to IDLE. A start during DONE is ignored.
- Latency, counted in edges after E until alu_done is high:
  - ADD/SUB: 2 (ADDSUB, then DONE).
  - MUL: WIDTH+3 (WIDTH+1 Booth iterations, then DONE).
  - DIV: WIDTH+3 (WIDTH iterations, DIV_FIX, then DONE).
  - DIV with B=0: 2.
- ADD/SUB:
  - Unsigned mode: alu_result = zero-extended (WIDTH+1)-bit result. Bit WIDTH is the carry for ADD and the borrow for SUB (1 when A<B). overflow = that bit.
  - Signed mode: alu_result = sign-extended WIDTH-bit result. overflow = two's-complement overflow.
- MUL: radix-2 Booth over WIDTH+1-bit operands. Operands are sign-extended in signed mode and zero-extended in unsigned mode. The accumulator is WIDTH+2 bits. Each iteration is add/sub per bit pair, then an arithmetic right shift. alu_result = full 2*WIDTH product. overflow=0.
- DIV: non-restoring division on magnitudes. The remainder register is WIDTH+1 bits: subtract when R>=0, add when R<0, shift in the quotient bit. DIV_FIX adds B once if R<0, then applies signs.
  - Signed mode: quotient is negated when the operand signs differ. The remainder takes the sign of the dividend (truncating division).
  - alu_result = {remainder, quotient}.
  - Signed MIN/-1: quotient=MIN, remainder=0, overflow=1.
- B=0 on DIV: skip iterations. quotient = all ones, remainder = A, div_by_zero=1.
- alu_result updates only on the edge that raises alu_done.

Decomposition:
- Shared package alu_pkg holds the op-code constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state encoding.
- One sub-module, alu_nr_div_core (WIDTH): the non-restoring iteration datapath with ld/step/fix controls and magnitude I/O.
- Booth, add/sub, FSM and sign handling stay in alu_seq_param.

Test Plan:
- WIDTH=8, unsigned ADD 200+100 -> alu_result=0x012C, overflow=1, done 2 edges after accept. Signed SUB 100-(-100) -> overflow=1, result=0xFFC8.
- WIDTH=8, signed MUL -5*6 -> 0xFFE2 with done exactly 11 edges after accept. Unsigned MUL 255*255 -> 0xFE01.
- WIDTH=8, unsigned DIV 40/6 -> 0x0406. Signed DIV -7/2 -> 0xFFFD. Signed -128/-1 -> 0x0080, overflow=1.
- DIV 77/0 -> alu_result=0x4DFF, div_by_zero=1, done after 2 edges. The next accepted ADD clears the flag.
- Start pulses while busy and in DONE are ignored: exactly one done, result from the first operands. Changing operands mid-MUL does not alter the result.
- Reset asserted mid-DIV (WIDTH=16): all outputs 0 immediately. A following 16-bit MUL 300*(-2) -> 0xFFFFFDA8.
